// File: rtl/reset_seq_ctrl.sv
// rtl/reset_seq_ctrl.sv - handshaked reset sequencer: fixed pulse, synchronized ready wait, ack/timeout
`timescale 1ns/1ps
module reset_seq_ctrl #(
  parameter int PULSE_LEN   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic clk,
  input  logic reset_loop_i_b,
  input  logic req_i,
  input  logic ready_i,
  output logic rst_o,
  output logic busy_o,
  output logic ack_o,
  output logic timeout_o
);

  localparam int CNT_MAX = (PULSE_LEN > TIMEOUT) ? PULSE_LEN : TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] PULSE_LAST   = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_RDY = 2'd2,
    ACK      = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   rst_d, busy_d, ack_d, timeout_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ready_s;

  // Flushed throughout ASSERT so a ready left over from a previous sequence cannot end WAIT_RDY early.
  always_ff @(posedge clk or posedge reset_loop_i_b) begin
    if (reset_loop_i_b) begin
      sync_q <= '0;
    end else if (state_q == ASSERT) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ready_i};
    end
  end

  assign ready_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset_loop_i_b) begin
    if (reset_loop_i_b) begin
      state_q   <= ASSERT;
      count_q   <= '0;
      rst_o     <= 1'b1;
      busy_o    <= 1'b1;
      ack_o     <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rst_o     <= rst_d;
      busy_o    <= busy_d;
      ack_o     <= ack_d;
      timeout_o <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rst_d     = rst_o;
    busy_d    = busy_o;
    ack_d     = 1'b0;
    timeout_d = timeout_o;
    case (state_q)
      IDLE: begin
        rst_d  = 1'b0;
        busy_d = 1'b0;
        if (req_i) begin
          state_d   = ASSERT;
          rst_d     = 1'b1;
          busy_d    = 1'b1;
          count_d   = '0;
          timeout_d = 1'b0;
        end
      end
      ASSERT: begin
        rst_d  = 1'b1;
        busy_d = 1'b1;
        if (count_q == PULSE_LAST) begin
          state_d = WAIT_RDY;
          rst_d   = 1'b0;
          count_d = '0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      WAIT_RDY: begin
        rst_d  = 1'b0;
        busy_d = 1'b1;
        // Ready takes priority when it coincides with the last allowed cycle.
        if (ready_s) begin
          state_d = ACK;
          ack_d   = 1'b1;
        end else if (count_q == TIMEOUT_LAST) begin
          state_d   = ACK;
          ack_d     = 1'b1;
          timeout_d = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        rst_d   = 1'b0;
        count_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// tb/tb_reset_seq_ctrl.sv - directed self-checking bench for reset_seq_ctrl
`timescale 1ns/1ps
module tb_reset_seq_ctrl;

  localparam int PULSE = 16;

  logic clk = 1'b0;
  logic reset_loop_i_b;
  logic req, ready, req_to, ready_to;
  logic rst_o, busy_o, ack_o, timeout_o;
  logic rst_to, busy_to, ack_to, timeout_to;

  int n_checks = 0;
  int n_errors = 0;
  int cur_cyc  = 0;

  always #5 clk = ~clk;

  reset_seq_ctrl dut (
    .clk            (clk),
    .reset_loop_i_b (reset_loop_i_b),
    .req_i          (req),
    .ready_i        (ready),
    .rst_o          (rst_o),
    .busy_o         (busy_o),
    .ack_o          (ack_o),
    .timeout_o      (timeout_o)
  );

  reset_seq_ctrl #(.TIMEOUT(8)) dut_to (
    .clk            (clk),
    .reset_loop_i_b (reset_loop_i_b),
    .req_i          (req_to),
    .ready_i        (ready_to),
    .rst_o          (rst_to),
    .busy_o         (busy_to),
    .ack_o          (ack_to),
    .timeout_o      (timeout_to)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cur_cyc, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Cycle 1 is the cycle after the accepting edge (or reset release).
  task automatic run_seq(input int ack_cyc, input int ncyc, input int ign1, input int ign2,
                         input int rdy_c);
    for (int c = 1; c <= ncyc; c++) begin
      cur_cyc = c;
      if (c == rdy_c) ready = 1'b1;
      check("rst_o", rst_o, (c <= PULSE));
      check("busy_o", busy_o, (c <= ack_cyc));
      check("ack_o", ack_o, (c == ack_cyc));
      check("timeout_o", timeout_o, 1'b0);
      req = (c == ign1) || (c == ign2);
      tick();
    end
    req = 1'b0;
  endtask

  initial begin
    reset_loop_i_b = 1'b1;
    req      = 1'b0;
    ready    = 1'b1;
    req_to   = 1'b0;
    ready_to = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      cur_cyc = -i;
      check("reset rst_o", rst_o, 1'b1);
      check("reset busy_o", busy_o, 1'b1);
      check("reset ack_o", ack_o, 1'b0);
      check("reset timeout_o", timeout_o, 1'b0);
      check("reset rst_to", rst_to, 1'b1);
    end
    reset_loop_i_b = 1'b0;
    run_seq(20, 22, 0, 0, 0);

    tick();
    check("idle rst_o", rst_o, 1'b0);
    check("idle busy_o", busy_o, 1'b0);

    req = 1'b1;
    tick();
    req = 1'b0;
    run_seq(20, 22, 0, 0, 0);

    req = 1'b1;
    tick();
    req = 1'b0;
    run_seq(20, 25, 5, 18, 0);

    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (7) tick();
    cur_cyc = 8;
    reset_loop_i_b = 1'b1;
    #1;
    check("midrst rst_o", rst_o, 1'b1);
    check("midrst busy_o", busy_o, 1'b1);
    tick();
    check("midrst ack_o", ack_o, 1'b0);
    tick();
    check("midrst ack_o 2", ack_o, 1'b0);
    reset_loop_i_b = 1'b0;
    run_seq(20, 22, 0, 0, 0);

    tick();
    req   = 1'b1;
    ready = 1'b0;
    tick();
    req = 1'b0;
    run_seq(30, 32, 0, 0, 27);

    cur_cyc = 0;
    check("to sticky pre", timeout_to, 1'b1);
    check("to idle busy", busy_to, 1'b0);
    req_to = 1'b1;
    tick();
    req_to = 1'b0;
    for (int c = 1; c <= 28; c++) begin
      cur_cyc = c;
      check("to rst", rst_to, (c <= PULSE));
      check("to busy", busy_to, (c <= 25));
      check("to ack", ack_to, (c == 25));
      check("to timeout", timeout_to, (c >= 25));
      tick();
    end
    repeat (3) tick();
    check("to sticky post", timeout_to, 1'b1);

    ready_to = 1'b1;
    req_to   = 1'b1;
    tick();
    req_to = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      cur_cyc = c;
      check("to2 timeout", timeout_to, 1'b0);
      check("to2 ack", ack_to, (c == 20));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
